// File: rtl/sd_clk_pkg.sv
// sd_clk_pkg: shared types and helpers for the SD clock generator.
// Holds the CSD TRAN_SPEED decode tables, the decode-valid check,
// the ceil-division used to size the identification-mode divisor,
// and the control FSM state type.
package sd_clk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_DIV    = 2'd2
    } ctrl_state_e;

    // Width of the divider datapath (numerator and 2*rate).
    localparam int unsigned DIV_W = 32'd33;

    // TRAN_SPEED time-value code (bits 6:3) to multiplier x10.
    function automatic logic [31:0] mult_lookup(input logic [3:0] code);
        case (code)
            4'h1:    return 32'd10;
            4'h2:    return 32'd12;
            4'h3:    return 32'd13;
            4'h4:    return 32'd15;
            4'h5:    return 32'd20;
            4'h6:    return 32'd25;
            4'h7:    return 32'd30;
            4'h8:    return 32'd35;
            4'h9:    return 32'd40;
            4'hA:    return 32'd45;
            4'hB:    return 32'd50;
            4'hC:    return 32'd55;
            4'hD:    return 32'd60;
            4'hE:    return 32'd70;
            4'hF:    return 32'd80;
            default: return 32'd0;
        endcase
    endfunction

    // TRAN_SPEED rate-unit code (bits 2:0) to Hz per multiplier step.
    function automatic logic [31:0] unit_lookup(input logic [2:0] code);
        case (code)
            3'd0:    return 32'd10_000;
            3'd1:    return 32'd100_000;
            3'd2:    return 32'd1_000_000;
            3'd3:    return 32'd10_000_000;
            default: return 32'd0;
        endcase
    endfunction

    // A TRAN_SPEED byte is usable only with bit 7 clear, a non-zero
    // multiplier code and a unit code in the defined range.
    function automatic logic decode_valid(input logic [7:0] ts);
        return (ts[7] == 1'b0) && (ts[6:3] != 4'd0) && (ts[2:0] <= 3'd3);
    endfunction

    // Ceiling division for elaboration-time constants.
    function automatic logic [63:0] ceil_div(input logic [63:0] num, input logic [63:0] den);
        if (den == 64'd0) begin
            return 64'd0;
        end else begin
            return (num + den - 64'd1) / den;
        end
    endfunction

endpackage

// File: rtl/sd_clk_gen_if.sv
// sd_clk_gen_if: control/status bundle between the CSD parser, the clock
// generator and the SD PHY. With SD_CLK_STROBE_EN defined the bundle also
// carries the sd_clk rise/fall strobes.
interface sd_clk_gen_if #(
    parameter int unsigned CNT_W = 32'd16
);
    logic             start;
    logic [7:0]       tran_speed;
    logic             init_mode;
    logic             clk_en;
    logic             busy;
    logic             ok;
    logic             err;
    logic [CNT_W-1:0] count;
    logic             sd_clk;
`ifdef SD_CLK_STROBE_EN
    logic             sd_clk_rise;
    logic             sd_clk_fall;

    modport master (
        output start, tran_speed, init_mode, clk_en,
        input  busy, ok, err, count, sd_clk, sd_clk_rise, sd_clk_fall
    );
    modport slave (
        input  start, tran_speed, init_mode, clk_en,
        output busy, ok, err, count, sd_clk, sd_clk_rise, sd_clk_fall
    );
`else
    modport master (
        output start, tran_speed, init_mode, clk_en,
        input  busy, ok, err, count, sd_clk
    );
    modport slave (
        input  start, tran_speed, init_mode, clk_en,
        output busy, ok, err, count, sd_clk
    );
`endif
endinterface

// File: rtl/sd_div_serial.sv
// sd_div_serial: restoring divider, one quotient bit per clock.
// The first quotient bit is resolved in the load cycle itself, so a
// W-bit division finishes W-1 cycles after start; done pulses for one
// cycle together with the final quotient. dbz flags a zero divisor.
module sd_div_serial #(
    parameter int unsigned W = 32'd33
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] numer,
    input  logic [W-1:0] denom,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quot,
    output logic         dbz
);
    localparam int unsigned IW = $clog2(W + 32'd1);

    logic [W-1:0]  rem_r;
    logic [W-1:0]  quot_r;
    logic [W-1:0]  den_r;
    logic [IW-1:0] iter_r;
    logic          busy_r;
    logic          done_r;
    logic          dbz_r;

    // One restoring step: shift in the next numerator bit, subtract if it fits.
    function automatic logic [2*W-1:0] div_step(input logic [W-1:0] rem,
                                                 input logic [W-1:0] q,
                                                 input logic [W-1:0] d);
        logic [W:0] trial;
        logic [W:0] diff;
        trial = {rem, q[W-1]};
        diff  = trial - {1'b0, d};
        if (trial >= {1'b0, d}) begin
            return {diff[W-1:0], q[W-2:0], 1'b1};
        end else begin
            return {trial[W-1:0], q[W-2:0], 1'b0};
        end
    endfunction

    // Load, iterate and flag completion of the division.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_r  <= {W{1'b0}};
            quot_r <= {W{1'b0}};
            den_r  <= {W{1'b0}};
            iter_r <= {IW{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (start && !busy_r) begin
                {rem_r, quot_r} <= div_step({W{1'b0}}, numer, denom);
                den_r           <= denom;
                dbz_r           <= (denom == {W{1'b0}});
                iter_r          <= IW'(W - 32'd1);
                busy_r          <= 1'b1;
            end else if (busy_r) begin
                {rem_r, quot_r} <= div_step(rem_r, quot_r, den_r);
                iter_r          <= iter_r - IW'(1);
                if (iter_r == IW'(1)) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign quot = quot_r;
    assign dbz  = dbz_r;

endmodule

// File: rtl/sd_clk_gen.sv
// sd_clk_gen: SD-card clock generator. Turns a CSD TRAN_SPEED byte into a
// half-period count via a serial divider, then divides the reference clock
// to produce sd_clk with glitch-free divisor switching (changes only land on
// a 1->0 edge), an identification-mode rate and a clock enable.
// Optional feature macro: SD_CLK_STROBE_EN adds sd_clk_rise/sd_clk_fall.
module sd_clk_gen
    import sd_clk_pkg::*;
#(
    parameter int unsigned REF_CLK_HZ = 32'd50_000_000,
    parameter int unsigned CNT_W      = 32'd16,
    parameter int unsigned INIT_HZ    = 32'd400_000
) (
    input  logic        clk,
    input  logic        reset,
    sd_clk_gen_if.slave bus
);
    localparam logic [CNT_W-1:0] INIT_N =
        CNT_W'(ceil_div(64'(REF_CLK_HZ), 64'(INIT_HZ) * 64'd2));

    ctrl_state_e      state_r;
    logic [7:0]       ts_r;
    logic             busy_r;
    logic             ok_r;
    logic             err_r;
    logic             dec_err_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] pending_r;
    logic [CNT_W-1:0] active_r;
    logic [CNT_W-1:0] phase_r;
    logic             sd_clk_r;
    logic             init_sel_r;

    logic [31:0]      rate_s;
    logic [DIV_W-1:0] numer_s;
    logic [DIV_W-1:0] denom_s;
    logic             div_start_s;
    logic             div_busy_s;
    logic             div_done_s;
    logic             div_dbz_s;
    logic [DIV_W-1:0] div_quot_s;
    logic             capture_s;
    logic             res_good_s;
    logic [CNT_W-1:0] pending_next_s;
    logic [CNT_W-1:0] eff_div_s;
    logic             phase_end_s;

    // Decode TRAN_SPEED into 2*rate and the rounded-up numerator.
    always_comb begin
        rate_s = 32'd0;
        if (decode_valid(ts_r)) begin
            rate_s = mult_lookup(ts_r[6:3]) * unit_lookup(ts_r[2:0]);
        end else begin
            rate_s = 32'd0;
        end
        denom_s = {rate_s, 1'b0};
        numer_s = DIV_W'(REF_CLK_HZ) + denom_s - DIV_W'(1);
    end

    // Result qualification, divisor bypass and phase-counter terminal count.
    always_comb begin
        div_start_s    = (state_r == ST_DECODE) && !div_busy_s;
        capture_s      = (state_r == ST_DIV) && div_done_s;
        res_good_s     = !dec_err_r && !div_dbz_s &&
                         ((div_quot_s >> CNT_W) == {DIV_W{1'b0}});
        pending_next_s = (capture_s && res_good_s) ? div_quot_s[CNT_W-1:0] : pending_r;
        eff_div_s      = init_sel_r ? INIT_N : active_r;
        phase_end_s    = (phase_r == (eff_div_s - CNT_W'(1)));
    end

    sd_div_serial #(
        .W(DIV_W)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .start (div_start_s),
        .numer (numer_s),
        .denom (denom_s),
        .busy  (div_busy_s),
        .done  (div_done_s),
        .quot  (div_quot_s),
        .dbz   (div_dbz_s)
    );

    // Request handshake: accept start when idle, decode, wait for the divider.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            ts_r      <= 8'd0;
            busy_r    <= 1'b0;
            ok_r      <= 1'b0;
            err_r     <= 1'b0;
            dec_err_r <= 1'b0;
            count_r   <= {CNT_W{1'b0}};
            pending_r <= INIT_N;
        end else begin
            ok_r  <= 1'b0;
            err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        ts_r    <= bus.tran_speed;
                        busy_r  <= 1'b1;
                        state_r <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    dec_err_r <= !decode_valid(ts_r);
                    if (div_start_s) begin
                        state_r <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    if (capture_s) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                        if (res_good_s) begin
                            ok_r      <= 1'b1;
                            count_r   <= div_quot_s[CNT_W-1:0];
                            pending_r <= div_quot_s[CNT_W-1:0];
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SD_CLK_STROBE_EN
    logic sd_clk_rise_r;
    logic sd_clk_fall_r;
    assign bus.sd_clk_rise = sd_clk_rise_r;
    assign bus.sd_clk_fall = sd_clk_fall_r;
`endif

    // sd_clk generation; divisor and init_mode are taken only at a 1->0 edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_r    <= {CNT_W{1'b0}};
            sd_clk_r   <= 1'b0;
            active_r   <= INIT_N;
            init_sel_r <= 1'b1;
`ifdef SD_CLK_STROBE_EN
            sd_clk_rise_r <= 1'b0;
            sd_clk_fall_r <= 1'b0;
`endif
        end else begin
`ifdef SD_CLK_STROBE_EN
            sd_clk_rise_r <= 1'b0;
            sd_clk_fall_r <= 1'b0;
`endif
            if (sd_clk_r) begin
                // A high phase always runs to completion, even with clk_en low.
                if (phase_end_s) begin
                    phase_r    <= {CNT_W{1'b0}};
                    sd_clk_r   <= 1'b0;
                    active_r   <= pending_next_s;
                    init_sel_r <= bus.init_mode;
`ifdef SD_CLK_STROBE_EN
                    sd_clk_fall_r <= 1'b1;
`endif
                end else begin
                    phase_r <= phase_r + CNT_W'(1);
                end
            end else if (!bus.clk_en) begin
                phase_r <= {CNT_W{1'b0}};
            end else if (phase_end_s) begin
                phase_r  <= {CNT_W{1'b0}};
                sd_clk_r <= 1'b1;
`ifdef SD_CLK_STROBE_EN
                sd_clk_rise_r <= 1'b1;
`endif
            end else begin
                phase_r <= phase_r + CNT_W'(1);
            end
        end
    end

    assign bus.busy   = busy_r;
    assign bus.ok     = ok_r;
    assign bus.err    = err_r;
    assign bus.count  = count_r;
    assign bus.sd_clk = sd_clk_r;

endmodule

// File: doc/sd_clk_gen.md
Name: sd_clk_gen

Overview:
Parametrised SD-card clock generator. Decodes the CSD TRAN_SPEED byte into a target bit rate. A serial divider computes the half-period count for the reference clock. The block then generates sd_clk from that count, with glitch-free divisor switching, an identification-mode (init) rate and a clock-enable. It sits between the command/CSD parser and the SD bus PHY, replacing the fixed one-shot count generator.

Parameters:
REF_CLK_HZ, 50_000_000, system clock frequency in Hz
CNT_W, 16, width of half-period count and counter
INIT_HZ, 400_000, identification-mode target rate; INIT_N = ceil(REF_CLK_HZ/(2*INIT_HZ)), elaboration constant (63 at defaults)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to compute a new divisor from tran_speed
tran_speed  in  8  CSD TRAN_SPEED byte
init_mode  in  1  1: sd_clk runs at INIT_N; 0: runs at last good computed count
clk_en  in  1  1: sd_clk toggles; 0: sd_clk parks low
busy  out  1  division in progress
ok  out  1  one-cycle pulse: computation succeeded
err  out  1  one-cycle pulse: computation failed
count  out  CNT_W  last successfully computed half-period count
sd_clk  out  1  generated SD clock, registered

Behaviour:
- One clock domain. The only clock and reset ports are clk and reset. Reset is asynchronous, active-high.
- Reset values:
  - busy=0, ok=0, err=0, count=0, sd_clk=0, phase counter=0.
  - Active divisor = INIT_N. Pending divisor = INIT_N.
- Decode:
  - Multiplier from tran_speed[6:3]: 1..F → 10,12,13,15,20,25,30,35,40,45,50,55,60,70,80.
  - Unit from tran_speed[2:0]: 0..3 → 10_000, 100_000, 1_000_000, 10_000_000.
  - rate = mult*unit, 32-bit.
  - Decode error if any of: mult code 0, unit code 4..7, tran_speed[7]=1.
- Division: N = ceil(REF_CLK_HZ/(2*rate)), computed as (REF_CLK_HZ + 2*rate - 1)/(2*rate).
  - 33-bit numerator and divisor; restoring algorithm, one quotient bit per cycle, 33 iterations.
  - N=0 cannot occur; minimum result is 1.
  - Overflow error if N > 2^CNT_W - 1.
- Handshake:
  - start is sampled only when busy=0; start while busy is ignored.
  - Cycle 0 samples start and registers tran_speed. busy=1 from cycle 1. Decode occurs in cycle 1.
  - Division runs in cycles 2..34. In cycle 35, busy=0 and exactly one of ok/err pulses.
  - On ok: count=N, pending divisor=N.
  - On err: count and pending divisor are unchanged. A decode error still runs the full 35-cycle latency, to keep timing deterministic.
- Clock generation:
  - Effective divisor D = INIT_N when init_mode=1, otherwise the active divisor.
  - The phase counter counts 0..D-1. At D-1 it wraps to 0 and sd_clk toggles. Each sd_clk half-period is exactly D clk cycles.
- Glitch-free switching:
  - The active divisor is loaded from the pending divisor only in the cycle sd_clk toggles 1→0.
  - init_mode is sampled only at that same point.
  - Every completed high and low phase therefore uses a single D.
- clk_en=0:
  - A high phase in progress completes normally.
  - sd_clk then stays 0 and the counter holds at 0.
  - On clk_en=1, a full low phase of D cycles runs before the next rise.
- Simultaneous events:
  - ok in the same cycle as a 1→0 toggle: the new N is loaded at that toggle.
  - reset mid-division: busy is cleared and no ok/err pulse is emitted.

Optional Feature:
Macro: SD_CLK_STROBE_EN.
- Defined: adds two ports, sd_clk_rise (out, 1) and sd_clk_fall (out, 1).
  - Each is a one-cycle pulse, asserted in the same cycle the registered sd_clk changes 0→1 or 1→0 respectively.
  - Both reset to 0.
  - The PHY uses them to drive and sample CMD/DAT.
- Undefined: both ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Package/include sd_clk_pkg holds:
  - the multiplier lookup function;
  - the unit lookup function;
  - the decode-valid function;
  - the ceil-division constant function used for INIT_N.
- One sub-module, sd_div_serial: parametrised restoring divider with start/busy/done and a divide-by-zero flag.
- sd_clk_gen instantiates sd_div_serial once.

Test Plan:
1. Reset release, init_mode=1, clk_en=1 → sd_clk period 126 clk, high 63 / low 63; count=0.
2. start with tran_speed=0x32 (25 MHz) → ok pulse 35 cycles after start, count=1. Then set init_mode=0 → after the next falling edge, sd_clk period = 2 clk.
3. tran_speed=0x2A (20 MHz) → count=2. tran_speed=0x08 (100 kHz) → count=250 with ok. With CNT_W=4, tran_speed=0x08 → err, count stays 0.
4. tran_speed=0x00, then 0x0C (unit 4), then 0x88 → each gives an err pulse after 35 cycles; count and sd_clk period unchanged.
5. Issue start while sd_clk is mid-high with count changing 63→1 → no high or low phase shorter than its governing D; the switch happens only at a 1→0 edge. A second start while busy is ignored (exactly one ok).
6. Drop clk_en mid-high → high completes and sd_clk parks low. Re-raise clk_en → first rise after exactly D cycles. Assert reset mid-division → busy=0, no ok/err, sd_clk=0 immediately.
